// File: rtl/iter_alu_if.sv
// iter_alu_if: start/busy/done handshake plus operand and result bus of the
// multi-cycle ALU. The master issues ops; the slave (the ALU) answers.
interface iter_alu_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [3:0]       op;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             overflow;
    logic             div_zero;
    logic             zero;

    modport master (
        output start, op, src_a, src_b,
        input  busy, done, result, hi, lo, overflow, div_zero, zero
    );

    modport slave (
        input  start, op, src_a, src_b,
        output busy, done, result, hi, lo, overflow, div_zero, zero
    );
endinterface

// File: rtl/iter_alu.sv
// iter_alu: multi-cycle MIPS ALU. Single-cycle logic/arith/shift ops, a
// shift-add multiplier and a restoring divider (one bit per cycle) writing
// HI/LO. Optional signed MULTS/DIVS under the ITER_ALU_SIGNED_EN macro.
module iter_alu #(
    parameter int WIDTH = 32
) (
    input  logic          clk,
    input  logic          rst,
    iter_alu_if.slave     bus
);
    localparam int SHW = $clog2(WIDTH);

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_AND   = 4'd2;
    localparam logic [3:0] OP_OR    = 4'd3;
    localparam logic [3:0] OP_NOR   = 4'd4;
    localparam logic [3:0] OP_SLT   = 4'd5;
    localparam logic [3:0] OP_SLL   = 4'd6;
    localparam logic [3:0] OP_SRL   = 4'd7;
    localparam logic [3:0] OP_MULT  = 4'd8;
    localparam logic [3:0] OP_DIV   = 4'd9;
`ifdef ITER_ALU_SIGNED_EN
    localparam logic [3:0] OP_MULTS = 4'd10;
    localparam logic [3:0] OP_DIVS  = 4'd11;
`endif

    typedef enum logic [2:0] {IDLE, EXEC, MUL, DIV, FIN} state_t;

    typedef struct packed {
        logic [3:0]       op;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } req_t;

    state_t             state;
    req_t               req_q;
    logic [2*WIDTH-1:0] work;     // MUL: {acc, multiplier}; DIV: {remainder, quotient}
    logic [WIDTH-1:0]   opnd;     // multiplicand or divisor magnitude
    logic [SHW-1:0]     count;

    logic               busy_q, done_q, ovf_q, dz_q, zero_q;
    logic [WIDTH-1:0]   result_q, hi_q, lo_q;

`ifdef ITER_ALU_SIGNED_EN
    logic               neg_p, neg_r;      // negate product/quotient, remainder
    logic               neg_p_d, neg_r_d;
`endif

    // accept-time decode: next state and operand magnitudes
    state_t             acc_state;
    logic [WIDTH-1:0]   mag_a, mag_b;

    always_comb begin
        acc_state = EXEC;
        mag_a     = bus.src_a;
        mag_b     = bus.src_b;
`ifdef ITER_ALU_SIGNED_EN
        neg_p_d   = 1'b0;
        neg_r_d   = 1'b0;
`endif
        case (bus.op)
            OP_MULT: acc_state = MUL;
            OP_DIV:  acc_state = DIV;
`ifdef ITER_ALU_SIGNED_EN
            OP_MULTS, OP_DIVS: begin
                acc_state = (bus.op == OP_MULTS) ? MUL : DIV;
                mag_a     = bus.src_a[WIDTH-1] ? -bus.src_a : bus.src_a;
                mag_b     = bus.src_b[WIDTH-1] ? -bus.src_b : bus.src_b;
                neg_p_d   = bus.src_a[WIDTH-1] ^ bus.src_b[WIDTH-1];
                neg_r_d   = (bus.op == OP_DIVS) && bus.src_a[WIDTH-1];
            end
`endif
            default: acc_state = EXEC;
        endcase
    end

    // single-cycle ALU on the latched request
    logic [WIDTH-1:0] add_res, sub_res, alu_res;
    logic             alu_ovf;
    logic [SHW-1:0]   shamt;

    assign add_res = req_q.a + req_q.b;
    assign sub_res = req_q.a - req_q.b;
    assign shamt   = req_q.a[SHW-1:0];

    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        case (req_q.op)
            OP_ADD: begin
                alu_res = add_res;
                alu_ovf = (req_q.a[WIDTH-1] == req_q.b[WIDTH-1]) &&
                          (add_res[WIDTH-1] != req_q.a[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = sub_res;
                alu_ovf = (req_q.a[WIDTH-1] != req_q.b[WIDTH-1]) &&
                          (sub_res[WIDTH-1] != req_q.a[WIDTH-1]);
            end
            OP_AND:  alu_res = req_q.a & req_q.b;
            OP_OR:   alu_res = req_q.a | req_q.b;
            OP_NOR:  alu_res = ~(req_q.a | req_q.b);
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(req_q.a) < $signed(req_q.b))};
            OP_SLL:  alu_res = req_q.b << shamt;
            OP_SRL:  alu_res = req_q.b >> shamt;
            default: alu_res = '0;
        endcase
    end

    // one iteration of the shift-add multiplier and restoring divider
    logic [WIDTH:0]     mul_sum, rem_sh, div_trial;
    logic [2*WIDTH-1:0] mul_next, div_next;

    assign mul_sum   = {1'b0, work[2*WIDTH-1:WIDTH]} + {1'b0, (work[0] ? opnd : '0)};
    assign mul_next  = {mul_sum, work[WIDTH-1:1]};
    assign rem_sh    = work[2*WIDTH-1:WIDTH-1];
    assign div_trial = rem_sh - {1'b0, opnd};
    assign div_next  = div_trial[WIDTH] ? {rem_sh[WIDTH-1:0], work[WIDTH-2:0], 1'b0}
                                        : {div_trial[WIDTH-1:0], work[WIDTH-2:0], 1'b1};

    // final HI/LO, with sign fix-up for the signed variants
    logic [WIDTH-1:0] fin_hi, fin_lo;

    always_comb begin
        fin_hi = work[2*WIDTH-1:WIDTH];
        fin_lo = work[WIDTH-1:0];
`ifdef ITER_ALU_SIGNED_EN
        if (req_q.op == OP_MULT || req_q.op == OP_MULTS) begin
            if (neg_p) {fin_hi, fin_lo} = -work;
        end else begin
            if (neg_p) fin_lo = -work[WIDTH-1:0];
            if (neg_r) fin_hi = -work[2*WIDTH-1:WIDTH];
        end
`endif
    end

    // control FSM with registered handshake and result outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            req_q    <= '0;
            work     <= '0;
            opnd     <= '0;
            count    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            ovf_q    <= 1'b0;
            dz_q     <= 1'b0;
            zero_q   <= 1'b1;
            result_q <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
`ifdef ITER_ALU_SIGNED_EN
            neg_p    <= 1'b0;
            neg_r    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (done_q) begin
                        // done cycle just ended; start is not sampled here
                        done_q <= 1'b0;
                        busy_q <= 1'b0;
                    end else if (bus.start) begin
                        req_q  <= '{op: bus.op, a: bus.src_a, b: bus.src_b};
                        work   <= {{WIDTH{1'b0}}, mag_a};
                        opnd   <= mag_b;
                        count  <= SHW'(WIDTH-1);
                        busy_q <= 1'b1;
                        dz_q   <= 1'b0;
                        state  <= acc_state;
`ifdef ITER_ALU_SIGNED_EN
                        neg_p  <= neg_p_d;
                        neg_r  <= neg_r_d;
`endif
                    end
                end
                EXEC: begin
                    result_q <= alu_res;
                    zero_q   <= (alu_res == '0);
                    ovf_q    <= alu_ovf;
                    done_q   <= 1'b1;
                    state    <= IDLE;
                end
                MUL: begin
                    work <= mul_next;
                    if (count == '0) state <= FIN;
                    else             count <= count - 1'b1;
                end
                DIV: begin
                    if (opnd == '0) begin
                        // divide by zero skips iteration entirely
                        hi_q   <= '0;
                        lo_q   <= '0;
                        dz_q   <= 1'b1;
                        done_q <= 1'b1;
                        state  <= IDLE;
                    end else begin
                        work <= div_next;
                        if (count == '0) state <= FIN;
                        else             count <= count - 1'b1;
                    end
                end
                FIN: begin
                    hi_q   <= fin_hi;
                    lo_q   <= fin_lo;
                    done_q <= 1'b1;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.result   = result_q;
    assign bus.hi       = hi_q;
    assign bus.lo       = lo_q;
    assign bus.overflow = ovf_q;
    assign bus.div_zero = dz_q;
    assign bus.zero     = zero_q;
endmodule

// File: tb/tb_iter_alu.sv
// tb_iter_alu: directed vectors for iter_alu (WIDTH=32). The driver pushes the
// hand-computed expected response into a queue on acceptance; a monitor pops
// and compares every output field plus latency whenever done pulses.
module tb_iter_alu;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    iter_alu_if #(.WIDTH(32)) bus ();
    iter_alu #(.WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        string       name;
        logic [3:0]  op;
        logic [31:0] a, b, res, hi, lo;
        logic        z, ovf, dz;
        int          lat;
        int          acc;
    } vec_t;

    vec_t exp_q[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // monitor: compare on every done pulse
    initial begin
        vec_t e;
        forever begin
            @(negedge clk);
            if (!rst && bus.done) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got done at cycle %0d expected none", cyc);
                end else begin
                    e = exp_q.pop_front();
                    chk({e.name, ".result"},   bus.result, e.res);
                    chk({e.name, ".zero"},     32'(bus.zero), 32'(e.z));
                    chk({e.name, ".overflow"}, 32'(bus.overflow), 32'(e.ovf));
                    chk({e.name, ".hi"},       bus.hi, e.hi);
                    chk({e.name, ".lo"},       bus.lo, e.lo);
                    chk({e.name, ".div_zero"}, 32'(bus.div_zero), 32'(e.dz));
                    chk({e.name, ".latency"},  32'(cyc - e.acc), 32'(e.lat));
                    chk({e.name, ".busy"},     32'(bus.busy), 32'd1);
                end
            end
        end
    end

    task automatic issue(input vec_t v, input bit push, input bit hold);
        int k;
        int bad;
        k = 0;
        while (bus.busy && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (bus.busy) begin
            checks++;
            errors++;
            $display("FAIL %s.idle_wait: got busy=1 expected 0 within 200 cycles", v.name);
        end
        bus.start = 1'b1;
        bus.op    = v.op;
        bus.src_a = v.a;
        bus.src_b = v.b;
        @(negedge clk);
        v.acc = cyc;
        if (push) exp_q.push_back(v);
        // scramble inputs: latched operands must be unaffected
        bus.start = 1'b0;
        bus.op    = 4'($urandom());
        bus.src_a = $urandom();
        bus.src_b = $urandom();
        if (hold) begin
            bad = 0;
            for (int j = 1; j <= v.lat; j++) begin
                @(negedge clk);
                if (!bus.busy) bad++;
                if (j == 5) begin
                    bus.start = 1'b1;
                    bus.op    = 4'd0;
                    bus.src_a = 32'd1;
                    bus.src_b = 32'd1;
                end
                if (j == 6) bus.start = 1'b0;
            end
            chk({v.name, ".busy_hold"}, 32'(bad), 32'd0);
        end
    endtask

    task automatic run(input string nm, input logic [3:0] op, input logic [31:0] a, b,
                       input logic [31:0] res, input logic z, ovf,
                       input logic [31:0] hi, lo, input logic dz, input int lat,
                       input bit hold = 1'b0);
        vec_t v;
        v.name = nm; v.op = op; v.a = a; v.b = b; v.res = res; v.z = z; v.ovf = ovf;
        v.hi = hi; v.lo = lo; v.dz = dz; v.lat = lat; v.acc = 0;
        issue(v, 1'b1, hold);
    endtask

    initial begin
        vec_t m;
        int k;
        bus.start = 1'b0;
        bus.op    = '0;
        bus.src_a = '0;
        bus.src_b = '0;
        repeat (3) @(negedge clk);
        chk("reset.busy",     32'(bus.busy), 32'd0);
        chk("reset.done",     32'(bus.done), 32'd0);
        chk("reset.result",   bus.result, 32'h0);
        chk("reset.hi",       bus.hi, 32'h0);
        chk("reset.lo",       bus.lo, 32'h0);
        chk("reset.zero",     32'(bus.zero), 32'd1);
        chk("reset.overflow", 32'(bus.overflow), 32'd0);
        chk("reset.div_zero", 32'(bus.div_zero), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        //   name        op     a             b             result        z  ov hi            lo            dz lat
        run("add_ovf",  4'd0, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 0, 1, 32'h0,        32'h0,        0, 1);
        run("sub_zero", 4'd1, 32'd5,        32'd5,        32'h0,        1, 0, 32'h0,        32'h0,        0, 1);
        run("slt_neg",  4'd5, 32'hFFFFFFFF, 32'h00000001, 32'h1,        0, 0, 32'h0,        32'h0,        0, 1);
        run("sll",      4'd6, 32'h00000024, 32'h00000001, 32'h10,       0, 0, 32'h0,        32'h0,        0, 1);
        run("srl",      4'd7, 32'h00000021, 32'h80000000, 32'h40000000, 0, 0, 32'h0,        32'h0,        0, 1);
        run("and",      4'd2, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 0, 0, 32'h0,        32'h0,        0, 1);
        run("or",       4'd3, 32'h0F0F0000, 32'h000000F0, 32'h0F0F00F0, 0, 0, 32'h0,        32'h0,        0, 1);
        run("nor",      4'd4, 32'h0,        32'h0,        32'hFFFFFFFF, 0, 0, 32'h0,        32'h0,        0, 1);
        run("sub_ovf",  4'd1, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 0, 1, 32'h0,        32'h0,        0, 1);
        run("mult_max", 4'd8, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h7FFFFFFF, 0, 1, 32'hFFFFFFFE, 32'h00000001, 0, 33, 1'b1);
        run("div_100_7",4'd9, 32'd100,      32'd7,        32'h7FFFFFFF, 0, 1, 32'd2,        32'd14,       0, 33);
        run("div_zero", 4'd9, 32'd9,        32'd0,        32'h7FFFFFFF, 0, 1, 32'h0,        32'h0,        1, 1);
        run("add_small",4'd0, 32'd3,        32'd4,        32'd7,        0, 0, 32'h0,        32'h0,        0, 1);
        run("undef_12", 4'd12,32'd5,        32'd6,        32'h0,        1, 0, 32'h0,        32'h0,        0, 1);
        run("mult_shift",4'd8,32'h12345678, 32'h00000100, 32'h0,        1, 0, 32'h12,       32'h34567800, 0, 33);
`ifdef ITER_ALU_SIGNED_EN
        run("mults",    4'd10,32'hFFFFFFFD, 32'd5,        32'h0,        1, 0, 32'hFFFFFFFF, 32'hFFFFFFF1, 0, 33);
        run("divs",     4'd11,32'hFFFFFFF9, 32'd2,        32'h0,        1, 0, 32'hFFFFFFFF, 32'hFFFFFFFD, 0, 33);
        run("divs_min", 4'd11,32'h80000000, 32'hFFFFFFFF, 32'h0,        1, 0, 32'h0,        32'h80000000, 0, 33);
`else
        run("undef_10", 4'd10,32'd3,        32'd5,        32'h0,        1, 0, 32'h12,       32'h34567800, 0, 1);
        run("undef_11", 4'd11,32'd7,        32'd0,        32'h0,        1, 0, 32'h12,       32'h34567800, 0, 1);
`endif

        // abort a MULT with reset partway through
        m.name = "mult_abort"; m.op = 4'd8; m.a = 32'd3; m.b = 32'd3; m.lat = 33;
        m.res = '0; m.hi = '0; m.lo = '0; m.z = 1'b0; m.ovf = 1'b0; m.dz = 1'b0; m.acc = 0;
        issue(m, 1'b0, 1'b0);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort.busy",   32'(bus.busy), 32'd0);
        chk("abort.done",   32'(bus.done), 32'd0);
        chk("abort.hi",     bus.hi, 32'h0);
        chk("abort.lo",     bus.lo, 32'h0);
        chk("abort.result", bus.result, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run("add_after",4'd0, 32'd1,        32'd1,        32'd2,        0, 0, 32'h0,        32'h0,        0, 1);

        k = 0;
        while (exp_q.size() != 0 && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d pending responses expected 0", exp_q.size());
        end
        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
